// File: rtl/wav_loader_if.sv
// Download-port and sample-RAM write-port bundle for the WAV loader.
// The host side drives ioctl_*; the loader drives ram_*.
interface wav_loader_if #(
  parameter int ADDR_W = 14
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ram_we, ram_addr, ram_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/wav_loader.sv
// Streaming WAV writer: validates the 44-byte canonical header, then copies the
// 8-bit mono PCM payload into sample RAM and reports sample rate and length.
module wav_loader #(
  parameter int ADDR_W = 14,
  parameter int INDEX  = 0
) (
  input  logic            clk_sys,
  input  logic            reset,
  wav_loader_if.slave     io,
  output logic [31:0]     sample_rate,
  output logic [ADDR_W:0] data_len,
  output logic            busy,
  output logic            valid,
  output logic            error,
  output logic            truncated
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

  state_t          state_r;
  logic            dl_r;
  logic [31:0]     data_size_r;

  logic            dl_rise_s;
  logic            dl_fall_s;
  logic            accept_s;
  logic            hdr_wr_s;
  logic            pay_wr_s;
  logic [24:0]     off_s;
  logic [31:0]     off32_s;
  logic            in_size_s;
  logic            in_cap_s;
  logic            store_s;
  logic            drop_over_s;
  logic [ADDR_W:0] inc_s;
  logic [ADDR_W:0] len_upd_s;
  logic [31:0]     lim_s;
  logic            short_s;

  // Fixed header bytes; unlisted offsets are don't-care.
  function automatic logic hdr_ok(input logic [5:0] a, input logic [7:0] b);
    logic ok;
    ok = 1'b1;
    case (a)
      6'd0:    ok = (b == 8'h52);
      6'd1:    ok = (b == 8'h49);
      6'd2:    ok = (b == 8'h46);
      6'd3:    ok = (b == 8'h46);
      6'd8:    ok = (b == 8'h57);
      6'd9:    ok = (b == 8'h41);
      6'd10:   ok = (b == 8'h56);
      6'd11:   ok = (b == 8'h45);
      6'd20:   ok = (b == 8'h01);
      6'd21:   ok = (b == 8'h00);
      6'd22:   ok = (b == 8'h01);
      6'd23:   ok = (b == 8'h00);
      6'd34:   ok = (b == 8'h08);
      6'd35:   ok = (b == 8'h00);
      6'd36:   ok = (b == 8'h64);
      6'd37:   ok = (b == 8'h61);
      6'd38:   ok = (b == 8'h74);
      6'd39:   ok = (b == 8'h61);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Edge detection and per-byte payload decisions; len_upd_s already includes
  // a byte arriving together with the download fall.
  always_comb begin
    dl_rise_s   = io.ioctl_download & ~dl_r;
    dl_fall_s   = ~io.ioctl_download & dl_r;
    accept_s    = dl_rise_s && (io.ioctl_index == 8'(INDEX));
    hdr_wr_s    = io.ioctl_wr && (io.ioctl_addr < 25'd44);
    pay_wr_s    = io.ioctl_wr && (io.ioctl_addr >= 25'd44);
    off_s       = io.ioctl_addr - 25'd44;
    off32_s     = {7'd0, off_s};
    in_size_s   = off32_s < data_size_r;
    in_cap_s    = off32_s < CAP;
    store_s     = (state_r == S_DATA) && pay_wr_s && in_size_s && in_cap_s;
    drop_over_s = (state_r == S_DATA) && pay_wr_s && in_size_s && !in_cap_s;
    inc_s       = off_s[ADDR_W:0] + {{ADDR_W{1'b0}}, 1'b1};
    if (store_s && (inc_s > data_len)) begin
      len_upd_s = inc_s;
    end else begin
      len_upd_s = data_len;
    end
    if (data_size_r < CAP) begin
      lim_s = data_size_r;
    end else begin
      lim_s = CAP;
    end
    short_s = {{(31-ADDR_W){1'b0}}, len_upd_s} < lim_s;
  end

  // Load FSM with registered RAM port and status outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r     <= S_IDLE;
      // Track the live level so a reset mid-transfer does not fake a new rise.
      dl_r        <= io.ioctl_download;
      data_size_r <= 32'd0;
      io.ram_we   <= 1'b0;
      io.ram_addr <= {ADDR_W{1'b0}};
      io.ram_data <= 8'd0;
      sample_rate <= 32'd0;
      data_len    <= {(ADDR_W+1){1'b0}};
      busy        <= 1'b0;
      valid       <= 1'b0;
      error       <= 1'b0;
      truncated   <= 1'b0;
    end else begin
      dl_r      <= io.ioctl_download;
      io.ram_we <= 1'b0;
      busy      <= (state_r == S_HEADER) || (state_r == S_DATA);
      if (accept_s) begin
        state_r     <= S_HEADER;
        data_size_r <= 32'd0;
        sample_rate <= 32'd0;
        data_len    <= {(ADDR_W+1){1'b0}};
        valid       <= 1'b0;
        error       <= 1'b0;
        truncated   <= 1'b0;
      end else begin
        case (state_r)
          S_HEADER: begin
            if (hdr_wr_s) begin
              case (io.ioctl_addr[5:0])
                6'd24:   sample_rate[7:0]   <= io.ioctl_dout;
                6'd25:   sample_rate[15:8]  <= io.ioctl_dout;
                6'd26:   sample_rate[23:16] <= io.ioctl_dout;
                6'd27:   sample_rate[31:24] <= io.ioctl_dout;
                6'd40:   data_size_r[7:0]   <= io.ioctl_dout;
                6'd41:   data_size_r[15:8]  <= io.ioctl_dout;
                6'd42:   data_size_r[23:16] <= io.ioctl_dout;
                6'd43:   data_size_r[31:24] <= io.ioctl_dout;
                default: sample_rate        <= sample_rate;
              endcase
            end
            if (hdr_wr_s && !hdr_ok(io.ioctl_addr[5:0], io.ioctl_dout)) begin
              state_r <= S_ERR;
              error   <= 1'b1;
            end else if (dl_fall_s) begin
              state_r <= S_ERR;
              error   <= 1'b1;
            end else if (hdr_wr_s && (io.ioctl_addr[5:0] == 6'd43)) begin
              state_r <= S_DATA;
            end else begin
              state_r <= S_HEADER;
            end
          end
          S_DATA: begin
            if (store_s) begin
              io.ram_we   <= 1'b1;
              io.ram_addr <= off_s[ADDR_W-1:0];
              io.ram_data <= io.ioctl_dout;
            end
            data_len <= len_upd_s;
            if (drop_over_s || (dl_fall_s && short_s)) begin
              truncated <= 1'b1;
            end
            if (dl_fall_s) begin
              state_r <= S_DONE;
              valid   <= 1'b1;
            end
          end
          default: state_r <= state_r;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wav_loader.sv
// Directed bench: two loaders (14-bit and 4-bit RAM) share one byte stream.
module tb_wav_loader;
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  wav_loader_if #(.ADDR_W(14)) bus14 ();
  wav_loader_if #(.ADDR_W(4))  bus4 ();

  logic [31:0] rate14, rate4;
  logic [14:0] len14;
  logic [4:0]  len4;
  logic busy14, valid14, err14, trunc14;
  logic busy4, valid4, err4, trunc4;

  wav_loader #(.ADDR_W(14), .INDEX(0)) dut14 (
    .clk_sys(clk_sys), .reset(reset), .io(bus14.slave),
    .sample_rate(rate14), .data_len(len14), .busy(busy14),
    .valid(valid14), .error(err14), .truncated(trunc14));

  wav_loader #(.ADDR_W(4), .INDEX(0)) dut4 (
    .clk_sys(clk_sys), .reset(reset), .io(bus4.slave),
    .sample_rate(rate4), .data_len(len4), .busy(busy4),
    .valid(valid4), .error(err4), .truncated(trunc4));

  int n_tests = 0;
  int n_fail  = 0;
  int wc14 = 0, wc4 = 0;
  int last14 = -1, last4 = -1;
  logic [7:0] mem14 [0:16383];
  logic [7:0] mem4  [0:15];

  // RAM port monitors sampled on the falling edge.
  always @(negedge clk_sys) begin
    if (bus14.ram_we === 1'b1) begin
      mem14[bus14.ram_addr] = bus14.ram_data;
      last14 = int'(bus14.ram_addr);
      wc14++;
    end
    if (bus4.ram_we === 1'b1) begin
      mem4[bus4.ram_addr] = bus4.ram_data;
      last4 = int'(bus4.ram_addr);
      wc4++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] file_byte(input int a, input logic [31:0] rate, input logic [31:0] dsize);
    logic [7:0] b;
    case (a)
      0: b = 8'h52;  1: b = 8'h49;  2: b = 8'h46;  3: b = 8'h46;
      8: b = 8'h57;  9: b = 8'h41; 10: b = 8'h56; 11: b = 8'h45;
      12: b = 8'h66; 13: b = 8'h6d; 14: b = 8'h74; 15: b = 8'h20;
      16: b = 8'h10; 20: b = 8'h01; 22: b = 8'h01; 32: b = 8'h01;
      34: b = 8'h08; 36: b = 8'h64; 37: b = 8'h61; 38: b = 8'h74; 39: b = 8'h61;
      24, 25, 26, 27: b = rate[8*(a-24) +: 8];
      28, 29, 30, 31: b = rate[8*(a-28) +: 8];
      40, 41, 42, 43: b = dsize[8*(a-40) +: 8];
      default: b = (a >= 44) ? pat(a - 44) : 8'h00;
    endcase
    return b;
  endfunction

  task automatic set_dl(input logic dl, input logic [7:0] idx);
    bus14.ioctl_download = dl; bus14.ioctl_index = idx;
    bus4.ioctl_download  = dl; bus4.ioctl_index  = idx;
  endtask

  task automatic set_wr(input logic wr, input logic [24:0] addr, input logic [7:0] d);
    bus14.ioctl_wr = wr; bus14.ioctl_addr = addr; bus14.ioctl_dout = d;
    bus4.ioctl_wr  = wr; bus4.ioctl_addr  = addr; bus4.ioctl_dout  = d;
  endtask

  task automatic pulse_reset();
    @(posedge clk_sys); #1 reset = 1'b1;
    @(posedge clk_sys); #1 reset = 1'b0;
  endtask

  // One download: nbytes file bytes, optional corrupted offset, optional reset after rst_off.
  task automatic run_file(input logic [7:0] idx, input logic [31:0] rate, input logic [31:0] dsize,
                          input int nbytes, input int bad_off, input logic [7:0] bad_val,
                          input int rst_off, input logic exp_busy);
    @(posedge clk_sys); #1 set_dl(1'b1, idx);
    repeat (2) @(posedge clk_sys);
    for (int a = 0; a < nbytes; a++) begin
      #1 set_wr(1'b1, 25'(a), (a == bad_off) ? bad_val : file_byte(a, rate, dsize));
      @(posedge clk_sys);
      #1 set_wr(1'b0, 25'(a), 8'h00);
      if (a == bad_off)     chk("err_after_bad_byte", 32'(err14), 32'd1);
      if (a == bad_off - 1) chk("err_before_bad_byte", 32'(err14), 32'd0);
      if (a == rst_off) begin
        reset = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
      end
      @(posedge clk_sys);
    end
    #1 chk("busy_before_fall", 32'(busy14), 32'(exp_busy));
    set_dl(1'b0, idx);
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b14, b4, bad;
    reset = 1'b1;
    set_dl(1'b0, 8'd0);
    set_wr(1'b0, 25'd0, 8'h00);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ram_we",    32'(bus14.ram_we),   32'd0);
    chk("rst_ram_addr",  32'(bus14.ram_addr), 32'd0);
    chk("rst_ram_data",  32'(bus14.ram_data), 32'd0);
    chk("rst_rate",      rate14,              32'd0);
    chk("rst_len",       32'(len14),          32'd0);
    chk("rst_busy",      32'(busy14),         32'd0);
    chk("rst_valid",     32'(valid14),        32'd0);
    chk("rst_error",     32'(err14),          32'd0);
    chk("rst_truncated", 32'(trunc14),        32'd0);
    reset = 1'b0;

    // Valid 8 kHz, 100-byte payload
    b14 = wc14;
    run_file(8'd0, 32'd8000, 32'd100, 144, -1, 8'h00, -1, 1'b1);
    chk("t1_writes", 32'(wc14 - b14), 32'd100);
    chk("t1_last_addr", 32'(last14), 32'd99);
    bad = 0;
    for (int i = 0; i < 100; i++) if (mem14[i] !== pat(i)) bad++;
    chk("t1_data_bad", 32'(bad), 32'd0);
    chk("t1_rate", rate14, 32'd8000);
    chk("t1_len", 32'(len14), 32'd100);
    chk("t1_valid", 32'(valid14), 32'd1);
    chk("t1_error", 32'(err14), 32'd0);
    chk("t1_trunc", 32'(trunc14), 32'd0);
    chk("t1_busy_done", 32'(busy14), 32'd0);

    // 16-bit sample width rejected at offset 34
    b14 = wc14;
    run_file(8'd0, 32'd8000, 32'd100, 144, 34, 8'h10, -1, 1'b0);
    chk("t2_writes", 32'(wc14 - b14), 32'd0);
    chk("t2_error", 32'(err14), 32'd1);
    chk("t2_valid", 32'(valid14), 32'd0);

    // Payload larger than a 16-byte RAM
    b14 = wc14; b4 = wc4;
    run_file(8'd0, 32'd11025, 32'd20, 64, -1, 8'h00, -1, 1'b1);
    chk("t3_writes4", 32'(wc4 - b4), 32'd16);
    chk("t3_last4", 32'(last4), 32'd15);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem4[i] !== pat(i)) bad++;
    chk("t3_data4_bad", 32'(bad), 32'd0);
    chk("t3_len4", 32'(len4), 32'd16);
    chk("t3_trunc4", 32'(trunc4), 32'd1);
    chk("t3_valid4", 32'(valid4), 32'd1);
    chk("t3_rate4", rate4, 32'd11025);
    chk("t3_writes14", 32'(wc14 - b14), 32'd20);
    chk("t3_len14", 32'(len14), 32'd20);
    chk("t3_trunc14", 32'(trunc14), 32'd0);

    // data_size 10 followed by 20 extra bytes and an 8-byte LIST chunk
    b14 = wc14;
    run_file(8'd0, 32'd22050, 32'd10, 44 + 38, -1, 8'h00, -1, 1'b1);
    chk("t4_writes", 32'(wc14 - b14), 32'd10);
    chk("t4_len", 32'(len14), 32'd10);
    chk("t4_trunc", 32'(trunc14), 32'd0);
    chk("t4_valid", 32'(valid14), 32'd1);

    // Payload ends before its declared size
    run_file(8'd0, 32'd8000, 32'd50, 44 + 20, -1, 8'h00, -1, 1'b1);
    chk("t5_len", 32'(len14), 32'd20);
    chk("t5_valid", 32'(valid14), 32'd1);
    chk("t5_trunc", 32'(trunc14), 32'd1);

    // File cut inside the header
    b14 = wc14;
    run_file(8'd0, 32'd8000, 32'd100, 30, -1, 8'h00, -1, 1'b1);
    chk("t6_error", 32'(err14), 32'd1);
    chk("t6_valid", 32'(valid14), 32'd0);
    chk("t6_writes", 32'(wc14 - b14), 32'd0);

    // Foreign index after reset is ignored
    pulse_reset();
    b14 = wc14;
    run_file(8'd1, 32'd8000, 32'd100, 144, -1, 8'h00, -1, 1'b0);
    chk("t7_writes", 32'(wc14 - b14), 32'd0);
    chk("t7_valid", 32'(valid14), 32'd0);
    chk("t7_error", 32'(err14), 32'd0);
    chk("t7_rate", rate14, 32'd0);

    // Reset at payload offset 5, then a fresh load
    b14 = wc14;
    run_file(8'd0, 32'd8000, 32'd100, 144, -1, 8'h00, 49, 1'b0);
    chk("t8_writes", 32'(wc14 - b14), 32'd6);
    chk("t8_rate", rate14, 32'd0);
    chk("t8_len", 32'(len14), 32'd0);
    chk("t8_valid", 32'(valid14), 32'd0);
    chk("t8_error", 32'(err14), 32'd0);
    chk("t8_trunc", 32'(trunc14), 32'd0);
    chk("t8_ram_addr", 32'(bus14.ram_addr), 32'd0);
    chk("t8_ram_data", 32'(bus14.ram_data), 32'd0);
    run_file(8'd0, 32'd16000, 32'd20, 64, -1, 8'h00, -1, 1'b1);
    chk("t8b_valid", 32'(valid14), 32'd1);
    chk("t8b_len", 32'(len14), 32'd20);
    chk("t8b_rate", rate14, 32'd16000);
    chk("t8b_error", 32'(err14), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wav_loader.md
# wav_loader

Streaming WAV-file writer for the sound test core. It sits between the `hps_io` download port and the sample RAM's write port, and is the write-side counterpart of the sample player that reads that RAM. It parses the 44-byte canonical RIFF/WAVE header as bytes arrive and rejects unsupported formats. It strips the header, writes the PCM payload to RAM starting at address 0, and publishes the sample rate and the payload length so the player can be configured.

## Interface
Parameters:
- `ADDR_W`, default 14: sample RAM address width; capacity is 2^ADDR_W bytes.
- `INDEX`, default 0: `ioctl_index` value this block accepts; downloads with any other index are ignored.

Ports:
- `clk_sys`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ioctl_download`  in  1  high for the duration of a file transfer.
- `ioctl_index`  in  8  file index of the current transfer.
- `ioctl_wr`  in  1  one-cycle strobe marking a valid byte.
- `ioctl_addr`  in  25  byte offset in the file.
- `ioctl_dout`  in  8  file byte.
- `ram_we`  out  1  sample RAM write strobe.
- `ram_addr`  out  ADDR_W  sample RAM address.
- `ram_data`  out  8  sample RAM data.
- `sample_rate`  out  32  header bytes 24–27, little-endian.
- `data_len`  out  ADDR_W+1  number of payload bytes written to RAM.
- `busy`  out  1  high while in HEADER or DATA.
- `valid`  out  1  high when the load completed with a good header.
- `error`  out  1  high when the header was rejected or the file was truncated.
- `truncated`  out  1  high when the payload exceeded RAM capacity or ended before its declared size.

## Operation
- States: IDLE, HEADER, DATA, DONE, ERR.
- Edge detection: `ioctl_download` is registered once to form `dl_rise` and `dl_fall`. A transfer is accepted only if `ioctl_index == INDEX` is true in the `dl_rise` cycle.
- Any state, on an accepted `dl_rise`:
  - clear `sample_rate`, `data_len`, `valid`, `error`, `truncated` and the internal `data_size`;
  - go to HEADER.
- HEADER. For each `ioctl_wr` with `ioctl_addr < 44`:
  - Check these fixed bytes. Bytes 0–3 = 52 49 46 46 ("RIFF"). Bytes 8–11 = 57 41 56 45 ("WAVE"). Byte 20 = 01 and byte 21 = 00 (PCM). Byte 22 = 01 and byte 23 = 00 (mono). Byte 34 = 08 and byte 35 = 00 (8-bit). Bytes 36–39 = 64 61 74 61 ("data").
  - On the first mismatch, go to ERR and set `error`=1.
  - Capture bytes 24–27 into `sample_rate` and bytes 40–43 into `data_size` (32-bit).
  - Bytes 4–7 and 12–19 are don't-care, as are bytes 28–33, which hold the byte rate and block align.
  - A write to offset 43 moves the state to DATA.
- DATA. For each `ioctl_wr` with `ioctl_addr >= 44`, let `off = ioctl_addr - 44`.
  - If `off < data_size` and `off < 2^ADDR_W`: write `ioctl_dout` to RAM at `off[ADDR_W-1:0]`, and set `data_len = off + 1` if that exceeds the current `data_len`.
  - If `off >= data_size`: drop the byte. This covers trailing chunks such as LIST.
  - If `off < data_size` but `off >= 2^ADDR_W`: drop the byte and set `truncated`=1.
- `dl_fall` handling:
  - In DATA: go to DONE and set `valid`=1. If `data_len < min(data_size, 2^ADDR_W)`, set `truncated`=1 while keeping `valid`=1.
  - In HEADER: go to ERR and set `error`=1.
  - In IDLE, DONE or ERR: no effect.
- ERR and DONE: hold until the next accepted `dl_rise`. No RAM writes occur in IDLE, HEADER, ERR or DONE.
- Writes are address-driven. Out-of-order or repeated offsets are handled per byte using the rules above; no counter is assumed.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `sample_rate`=0, `data_len`=0, `busy`=0, `valid`=0, `error`=0, `truncated`=0; state = IDLE.
- Reset during a transfer: go to IDLE immediately. The remainder of that transfer is ignored because no new `dl_rise` occurs.
- RAM write latency:
  - `ram_we`, `ram_addr` and `ram_data` are registered, one cycle after `ioctl_wr`.
  - `ram_we` is a single-cycle pulse per accepted byte.
  - `ram_addr` and `ram_data` hold their values when `ram_we`=0.
- Header latency: the transition to DATA or ERR is visible the cycle after the deciding `ioctl_wr`. `error` asserts in that same cycle.
- `ioctl_wr` in the same cycle as `dl_fall`: the byte is processed first. `data_len` and the DONE check include it, and `valid` asserts the next cycle.
- `dl_rise` while in DATA (a back-to-back transfer): restart cleanly as a new HEADER.
- `busy` is registered and tracks the state with one cycle of latency.

## Test plan
- Valid 44+100-byte file: 8 kHz, `data_size`=100, index 0 → 100 `ram_we` pulses at addresses 0..99 with matching data; `sample_rate`=8000; `data_len`=100; `valid`=1; `error`=0; `truncated`=0.
- Byte 34 = 0x10 (16-bit): `error`=1 the cycle after offset 34; zero `ram_we` pulses; `valid` stays 0 after `dl_fall`.
- `ADDR_W`=4 with `data_size`=20 and 20 payload bytes: 16 writes at addresses 0..15; `data_len`=16; `truncated`=1; `valid`=1.
- `data_size`=10 with 30 payload bytes plus a LIST chunk: exactly 10 writes; `data_len`=10; `truncated`=0.
- File ends after 30 bytes → ERR with `error`=1. A download with `ioctl_index`=1 → state stays IDLE with no writes.
- Assert `reset` for one cycle at payload offset 5, then run a fresh valid download → all outputs return to 0 and the second load completes with `valid`=1.
